column_frame_renderer: RTL and testbench

//  Parametrised double-buffered column-height store plus wall/ceiling/floor pixel shader for the raycaster.
//  The ray/height pipeline fills the back bank one column at a time. The display reads the front bank.

---
 rtl/column_frame_renderer.sv | 186 ++++++++++++++++++
 tb/tb_column_frame_renderer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/column_frame_renderer.sv
// Double-buffered column-height store and wall/ceiling/floor shader.
// The back bank fills column by column; the front bank feeds the display.
module column_frame_renderer #(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          POS_W     = 10,
    parameter int          HEIGHT_W  = 9,
    parameter logic [11:0] WALL_RGB  = 12'hF00,
    parameter logic [11:0] CEIL_RGB  = 12'h000,
    parameter logic [11:0] FLOOR_RGB = 12'h222
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_ce,
    input  logic [POS_W-1:0]    h_pos,
    input  logic [POS_W-1:0]    v_pos,
    input  logic                wr_valid,
    input  logic [POS_W-1:0]    wr_col,
    input  logic [HEIGHT_W-1:0] wr_height,
    input  logic                wr_side,
    output logic                wr_ready,
    output logic                frame_req,
    output logic                frame_swapped,
    output logic [3:0]          rgb_r,
    output logic [3:0]          rgb_g,
    output logic [3:0]          rgb_b
);

    localparam int AW = $clog2(H_RES);
    localparam int DW = HEIGHT_W + 1;
    localparam logic [POS_W:0] MID  = (POS_W+1)'(V_RES / 2);
    localparam logic [POS_W:0] VMAX = (POS_W+1)'(V_RES - 1);

    typedef enum logic [1:0] {
        REQ,
        FILL,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic          front_sel;
    logic          frame_valid;
    logic [DW-1:0] bank0 [H_RES];
    logic [DW-1:0] bank1 [H_RES];

    logic          fe;
    logic          swap;
    logic          wr_in;
    logic          wr_last;
    logic          rd_in;
    logic [DW-1:0] rd_word;

    assign fe      = pix_ce && (h_pos == POS_W'(H_RES - 1))
                            && (v_pos == POS_W'(V_RES - 1));
    assign swap    = fe && (state == DONE);
    assign wr_in   = wr_col < POS_W'(H_RES);
    assign wr_last = wr_col == POS_W'(H_RES - 1);

    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        frame_req  = 1'b0;
        unique case (state)
            REQ: begin
                frame_req  = !reset;
                state_next = FILL;
            end
            FILL: begin
                wr_ready = 1'b1;
                if (wr_valid && wr_last) state_next = DONE;
            end
            DONE: begin
                if (fe) state_next = REQ;
            end
            default: state_next = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= REQ;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            front_sel     <= 1'b0;
            frame_valid   <= 1'b0;
            frame_swapped <= 1'b0;
        end else begin
            frame_swapped <= swap;
            if (swap) begin
                front_sel   <= ~front_sel;
                frame_valid <= 1'b1;
            end
        end
    end

    // Bank storage is never cleared; frame_valid hides stale contents.
    always_ff @(posedge clk) begin
        if (!reset && wr_ready && wr_valid && wr_in) begin
            if (front_sel) bank0[wr_col[AW-1:0]] <= {wr_side, wr_height};
            else           bank1[wr_col[AW-1:0]] <= {wr_side, wr_height};
        end
    end

    assign rd_in = h_pos < POS_W'(H_RES);

    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = front_sel ? bank1[h_pos[AW-1:0]]
                                : bank0[h_pos[AW-1:0]];
        end
    end

    logic [DW-1:0]    s1_word;
    logic [POS_W-1:0] s1_h;
    logic [POS_W-1:0] s1_v;
    logic             s1_valid;

    // Bank word and frame_valid are captured together so a swap cannot split a pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_word  <= '0;
            s1_h     <= '0;
            s1_v     <= '0;
            s1_valid <= 1'b0;
        end else if (pix_ce) begin
            s1_word  <= rd_word;
            s1_h     <= h_pos;
            s1_v     <= v_pos;
            s1_valid <= frame_valid;
        end
    end

    logic [HEIGHT_W-1:0] height;
    logic [POS_W:0]      half;
    logic [POS_W:0]      top;
    logic [POS_W:0]      bottom;
    logic [POS_W:0]      vv;
    logic [11:0]         wall;
    logic [11:0]         color;

    assign height = s1_word[HEIGHT_W-1:0];
    assign half   = (POS_W+1)'(height >> 1);
    assign vv     = {1'b0, s1_v};
    assign wall   = s1_word[HEIGHT_W] ? ((WALL_RGB >> 1) & 12'h777)
                                      : WALL_RGB;

    always_comb begin
        top    = '0;
        bottom = VMAX;
        if (half < MID) begin
            top    = MID - half;
            bottom = MID + half;
        end
    end

    always_comb begin
        color = '0;
        if (!s1_valid || s1_h >= POS_W'(H_RES) || s1_v >= POS_W'(V_RES)) begin
            color = '0;
        end else if (height == '0) begin
            color = (vv < MID) ? CEIL_RGB : FLOOR_RGB;
        end else if (vv < top) begin
            color = CEIL_RGB;
        end else if (vv > bottom) begin
            color = FLOOR_RGB;
        end else begin
            color = wall;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_r <= '0;
            rgb_g <= '0;
            rgb_b <= '0;
        end else if (pix_ce) begin
            {rgb_r, rgb_g, rgb_b} <= color;
        end
    end

endmodule

// File: tb/tb_column_frame_renderer.sv
// Directed bench for column_frame_renderer with a pixel scoreboard.
module tb_column_frame_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_ce;
    logic [9:0] h_pos;
    logic [9:0] v_pos;
    logic       wr_valid;
    logic [9:0] wr_col;
    logic [8:0] wr_height;
    logic       wr_side;
    logic       wr_ready;
    logic       frame_req;
    logic       frame_swapped;
    logic [3:0] rgb_r;
    logic [3:0] rgb_g;
    logic [3:0] rgb_b;

    column_frame_renderer dut (
        .clk(clk),
        .reset(reset),
        .pix_ce(pix_ce),
        .h_pos(h_pos),
        .v_pos(v_pos),
        .wr_valid(wr_valid),
        .wr_col(wr_col),
        .wr_height(wr_height),
        .wr_side(wr_side),
        .wr_ready(wr_ready),
        .frame_req(frame_req),
        .frame_swapped(frame_swapped),
        .rgb_r(rgb_r),
        .rgb_g(rgb_g),
        .rgb_b(rgb_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
    } px_t;

    px_t q[$];
    int  ncmp = 0;
    int  nbad = 0;

    // Reference picture: two banks, front selector, valid flag.
    int  mh [2][640];
    bit  ms [2][640];
    int  msel = 0;
    bit  disp_valid = 1'b0;
    bit  last_swapped;
    bit  last_req;

    task automatic check(input string tag, input logic [11:0] obs,
                         input logic [11:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] expect_px(input int x, input int y);
        int h, half, top, bot;
        if (!disp_valid || x >= 640 || y >= 480) return 12'h000;
        h    = mh[msel][x];
        half = h / 2;
        if (half >= 240) begin
            top = 0;
            bot = 479;
        end else begin
            top = 240 - half;
            bot = 240 + half;
        end
        if (h == 0) return (y < 240) ? 12'h000 : 12'h222;
        if (y < top) return 12'h000;
        if (y > bot) return 12'h222;
        return ms[msel][x] ? 12'h700 : 12'hF00;
    endfunction

    task automatic pix(input int x, input int y);
        px_t e;
        @(negedge clk);
        pix_ce = 1'b1;
        h_pos  = 10'(x);
        v_pos  = 10'(y);
        e.x = x;
        e.y = y;
        e.rgb = expect_px(x, y);
        q.push_back(e);
        @(negedge clk);
        pix_ce = 1'b0;
        last_swapped = frame_swapped;
        last_req     = frame_req;
        if (q.size() > 1) begin
            e = q.pop_front();
            check($sformatf("px(%0d,%0d)", e.x, e.y),
                  {rgb_r, rgb_g, rgb_b}, e.rgb);
        end
    endtask

    task automatic flush();
        pix(700, 700);
    endtask

    task automatic do_fe(input bit exp_swap);
        pix(639, 479);
        check("frame_swapped", 12'(last_swapped), 12'(exp_swap));
        if (exp_swap) begin
            check("frame_req_after_swap", 12'(last_req), 12'h1);
            msel       = 1 - msel;
            disp_valid = 1'b1;
            @(negedge clk);
            check("swap_pulse_width", 12'(frame_swapped), 12'h0);
        end
    endtask

    task automatic write_col(input int c, input int ht, input bit sd);
        int n;
        @(negedge clk);
        n = 0;
        while (!wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) check($sformatf("wr_ready_wait col%0d", c), 12'(wr_ready), 12'h1);
        wr_valid  = 1'b1;
        wr_col    = 10'(c);
        wr_height = 9'(ht);
        wr_side   = sd;
        @(negedge clk);
        wr_valid = 1'b0;
        if (c < 640) begin
            mh[1-msel][c] = ht;
            ms[1-msel][c] = sd;
        end
    endtask

    task automatic write_range(input int lo, input int hi, input int ht,
                               input int side_col);
        for (int c = lo; c <= hi; c++) write_col(c, ht, c == side_col);
    endtask

    initial begin
        reset = 1'b1; pix_ce = 1'b0; h_pos = '0; v_pos = '0;
        wr_valid = 1'b0; wr_col = '0; wr_height = '0; wr_side = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rgb", {rgb_r, rgb_g, rgb_b}, 12'h000);
        check("reset_frame_req", 12'(frame_req), 12'h0);
        check("reset_wr_ready", 12'(wr_ready), 12'h0);
        check("reset_swapped", 12'(frame_swapped), 12'h0);

        // 1: release
        reset = 1'b0;
        #1;
        check("rel_frame_req", 12'(frame_req), 12'h1);
        check("rel_wr_ready0", 12'(wr_ready), 12'h0);
        @(negedge clk);
        check("rel_frame_req_end", 12'(frame_req), 12'h0);
        check("rel_wr_ready1", 12'(wr_ready), 12'h1);
        pix(10, 240);
        flush();

        // 2: h=100 frame, discarded out-of-range column first
        write_col(640, 50, 1'b1);
        check("oob_keeps_fill", 12'(wr_ready), 12'h1);
        write_range(0, 639, 100, -1);
        check("done_wr_ready", 12'(wr_ready), 12'h0);
        do_fe(1'b1);
        pix(10, 189); pix(10, 190); pix(10, 240);
        pix(10, 290); pix(10, 291); pix(645, 100);
        flush();

        // 3: side 1 on column 5
        write_range(0, 639, 100, 5);
        do_fe(1'b1);
        pix(5, 189); pix(5, 190); pix(5, 240); pix(5, 290);
        pix(6, 240); pix(4, 240);
        flush();

        // 4: full-height then zero-height frames
        write_range(0, 639, 500, -1);
        do_fe(1'b1);
        pix(0, 0); pix(320, 240); pix(0, 479); pix(639, 0);
        flush();
        write_range(0, 639, 0, -1);
        do_fe(1'b1);
        pix(100, 239); pix(100, 240); pix(0, 0); pix(639, 478);
        flush();

        // 5: partial frame does not swap
        write_range(0, 300, 100, -1);
        do_fe(1'b0);
        pix(100, 239); pix(100, 240); pix(100, 200);
        flush();
        write_range(301, 639, 100, -1);
        do_fe(1'b1);
        pix(100, 200); pix(400, 200); pix(400, 100);
        flush();

        // 6: reset mid-fill
        write_range(0, 50, 300, -1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midfill_rst_rgb", {rgb_r, rgb_g, rgb_b}, 12'h000);
        @(negedge clk);
        reset = 1'b0;
        msel = 0;
        disp_valid = 1'b0;
        q.delete();
        #1;
        check("midfill_frame_req", 12'(frame_req), 12'h1);
        pix(100, 200); pix(400, 300);
        do_fe(1'b0);
        flush();
        write_range(0, 639, 100, -1);
        do_fe(1'b1);
        pix(100, 200); pix(100, 100); pix(100, 400);
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
